rr_alu_scheduler: RTL and testbench
===================================

Name: rr_alu_scheduler

Overview:
- Sequential round-robin scheduler that shares one ALU among N requesters.
- Issues a one-hot grant, pulses the ALU start, and holds the grant until the ALU reports done or a watchdog expires.
- Rotates priority so the last-served requester has lowest priority next round.
- Sits between the requester ports and the shared ALU datapath; its core selection is the right (lowest-index-first) arbiter function.

Parameters:
- N, 16, number of requesters.
- IDW, 4, width of grant index; equals clog2(N).
- TIMEOUT, 64, maximum WAIT cycles before the grant is forcibly released; must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- alu_done  input  1  ALU completion pulse, one cycle.
- grant  output  N  one-hot grant, registered.
- grant_id  output  IDW  binary index of granted requester; 0 when grant is 0.
- grant_valid  output  1  high while any grant is held.
- alu_start  output  1  one-cycle pulse in the first cycle of a grant.
- timeout  output  1  one-cycle pulse when the watchdog releases a grant.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - grant, grant_id, grant_valid, alu_start and timeout are all 0.
  - Rotation pointer ptr = 0, watchdog counter = 0, state = IDLE.
  - Reset mid-operation aborts the operation silently; no timeout pulse is generated.
- Selection (combinational, evaluated in IDLE only):
  - masked = req & {bits with index >= ptr}.
  - If masked != 0, pick the lowest set bit of masked; otherwise pick the lowest set bit of req.
  - If req == 0, there is no pick.
- IDLE:
  - If req != 0 at a clock edge: register grant = one-hot pick, grant_id = pick index, grant_valid = 1, alu_start = 1, then go to ISSUE.
  - Otherwise stay in IDLE with all outputs 0.
- ISSUE (exactly one cycle): alu_start = 1 and the grant is held. alu_done is ignored in this state. Next state is WAIT with counter = 0.
- WAIT:
  - alu_start = 0, grant held, counter increments every cycle.
  - alu_done sampled high: at that edge clear grant, grant_id and grant_valid, set ptr = (grant_id + 1) mod N, go to IDLE.
  - counter == TIMEOUT-1 without alu_done: same release and ptr update, plus timeout = 1 for one cycle.
  - alu_done and timeout in the same cycle: done wins and no timeout pulse is generated.
- Latency:
  - req seen at edge E gives grant and alu_start visible after E.
  - alu_done seen at edge D gives grant = 0 after D.
  - There is at least one IDLE cycle between consecutive grants, so back-to-back grants are separated by one idle cycle.
- Grant stickiness:
  - The grant is held for the full operation even if the granted req drops. Operations are never aborted by req.
  - Changes to other req bits during ISSUE/WAIT have no effect.
- Stray alu_done in IDLE is ignored.
- Wrap-around: ptr = 15 followed by a grant to 15 gives ptr = 0.
- Fairness: with all requests held high, each requester is served once per N grants.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2), default N/IDW/TIMEOUT constants, and the one-hot-to-index function.
- One sub-module, right_pick: combinational lowest-set-bit picker with ports vec[N], onehot[N] and any.
  - Instantiated twice: once on masked, once on req.
  - The top selects between the two results with masked_any.

Test Plan:
1. Single request: req = 0x0008 from reset.
   - Next cycle: grant = 0x0008, grant_id = 3, alu_start high for 1 cycle.
   - alu_done 3 cycles later: grant = 0 on the next cycle, ptr = 4.
2. Full contention: req = 0xFFFF held, ALU answers done 1 cycle after start.
   - Grant ids are 0, 1, 2, … 15, 0, in order, each separated by one IDLE cycle.
3. Rotation masking: ptr = 4 (after serving id 3), req = 0x0009.
   - masked is empty, so grant id 0 and ptr becomes 1; the next grant is id 3.
4. Watchdog: grant id 5 and alu_done never asserted.
   - timeout pulses exactly once, 64 cycles after WAIT entry.
   - grant drops, ptr = 6; a late alu_done in IDLE is ignored.
5. Reset mid-operation: assert rst_n low between clock edges while in WAIT.
   - All outputs 0 immediately, ptr = 0.
   - After release, req = 0x0010 is granted id 4.
6. Request withdrawal and coincidence:
   - Granted req drops during WAIT: grant is held until alu_done.
   - alu_done on the same cycle as counter = TIMEOUT-1: release with no timeout pulse.

Source files
------------

// File: rtl/rr_alu_scheduler_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Holds the FSM encoding, default sizing and the one-hot to index helper.
package rr_alu_scheduler_pkg;

  localparam int unsigned NDefault       = 16;
  localparam int unsigned IdwDefault     = 4;
  localparam int unsigned TimeoutDefault = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  // Input must be one-hot or zero; zero maps to index 0.
  function automatic int unsigned onehot_to_idx(input logic [63:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_alu_scheduler_right_pick.sv
// Combinational lowest-set-bit picker used for both the masked and raw request vectors.
module right_pick #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;

endmodule

// File: rtl/rr_alu_scheduler.sv
// Round-robin scheduler sharing one ALU among N requesters.
// Grants are held until alu_done or the watchdog releases them.
module rr_alu_scheduler
  import rr_alu_scheduler_pkg::*;
#(
  parameter int unsigned N       = NDefault,
  parameter int unsigned IDW     = IdwDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           alu_done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           alu_start,
  output logic           timeout
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic [N-1:0] mask, masked, masked_oh, req_oh, pick_oh;
  logic         masked_any, req_any;
  logic         release_now;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr_q));
    end
  end

  assign masked = req & mask;

  right_pick #(.N(N)) u_pick_masked (
    .vec    (masked),
    .onehot (masked_oh),
    .any    (masked_any)
  );

  right_pick #(.N(N)) u_pick_req (
    .vec    (req),
    .onehot (req_oh),
    .any    (req_any)
  );

  // Fall back to the unmasked pick when nothing at or above ptr is requesting.
  assign pick_oh = masked_any ? masked_oh : req_oh;

  assign release_now = alu_done || (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          grant_d    = pick_oh;
          grant_id_d = IDW'(onehot_to_idx(64'(pick_oh)));
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (release_now) begin
          grant_d    = '0;
          grant_id_d = '0;
          cnt_d      = '0;
          ptr_d      = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);
          // A coincident alu_done suppresses the watchdog pulse.
          timeout_d  = !alu_done;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        cnt_d      = '0;
        state_d    = StIdle;
      end
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_id    = grant_id_q;
    grant_valid = (state_q != StIdle);
    alu_start   = (state_q == StIssue);
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_rr_alu_scheduler.sv
// Self-checking bench for rr_alu_scheduler: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_rr_alu_scheduler;

  localparam int N  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         alu_done;
  logic [N-1:0] grant;
  logic [3:0]   grant_id;
  logic         grant_valid;
  logic         alu_start;
  logic         timeout;

  always #5 clk = ~clk;

  rr_alu_scheduler #(.N(16), .IDW(4), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .alu_done    (alu_done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .alu_start   (alu_start),
    .timeout     (timeout)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who owns the ALU, how many edges since the grant, rotation point.
  bit m_busy;
  int m_owner;
  int m_age;
  int m_ptr;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_age   = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
  endtask

  // Circular search starting at ptr: first requester found gets the grant.
  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic d);
    int p;
    m_to = 1'b0;
    if (!m_busy) begin
      p = ref_pick(r, m_ptr);
      if (p >= 0) begin
        m_busy  = 1'b1;
        m_owner = p;
        m_age   = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (d || m_age == TO) begin
      m_to   = !d;
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    check("grant_id", 32'(grant_id), m_busy ? 32'(m_owner) : 32'd0);
    check("grant_valid", 32'(grant_valid), 32'(m_busy));
    check("alu_start", 32'(alu_start), 32'(m_busy && m_age == 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic d);
    req      = r;
    alu_done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    alu_done = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc('0, 1'b0);
  endtask

  initial begin
    int hit;
    bit slow;
    logic [N-1:0] r;
    logic d;

    rst_n    = 1'b0;
    req      = '0;
    alu_done = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from reset.
    cyc(16'h0008, 1'b0);
    check("t1_grant", 32'(grant), 32'h8);
    check("t1_id", 32'(grant_id), 32'd3);
    check("t1_start", 32'(alu_start), 32'd1);
    cyc('0, 1'b0);
    check("t1_start_drop", 32'(alu_start), 32'd0);
    cyc('0, 1'b0);
    cyc('0, 1'b1);
    check("t1_release", 32'(grant), 32'd0);

    // Rotation masking with ptr at 4.
    cyc(16'h0009, 1'b0);
    check("t3_first", 32'(grant_id), 32'd0);
    cyc(16'h0009, 1'b0);
    cyc(16'h0009, 1'b1);
    cyc(16'h0009, 1'b0);
    check("t3_second", 32'(grant_id), 32'd3);
    cyc('0, 1'b0);
    cyc('0, 1'b1);

    // Full contention from ptr 0.
    do_reset();
    for (int k = 0; k <= N; k++) begin
      cyc(16'hFFFF, 1'b0);
      check("t2_seq", 32'(grant_id), 32'(k % N));
      cyc(16'hFFFF, 1'b0);
      cyc(16'hFFFF, 1'b1);
    end

    // Watchdog on id 5.
    do_reset();
    cyc(16'h0020, 1'b0);
    check("t4_id", 32'(grant_id), 32'd5);
    cyc('0, 1'b0);
    hit = -1;
    for (int k = 1; k <= 100; k++) begin
      cyc('0, 1'b0);
      if (timeout) begin
        hit = k;
        break;
      end
    end
    check("t4_wd_cycles", 32'(hit), 32'd64);
    cyc('0, 1'b1);
    check("t4_late_done", 32'(grant_valid), 32'd0);
    cyc(16'h0041, 1'b0);
    check("t4_ptr6", 32'(grant_id), 32'd6);
    cyc('0, 1'b0);
    cyc('0, 1'b1);

    // Reset in the middle of WAIT.
    cyc(16'h0004, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    #3;
    do_reset();
    cyc(16'h0010, 1'b0);
    check("t5_id", 32'(grant_id), 32'd4);
    cyc('0, 1'b0);
    cyc('0, 1'b1);

    // Granted request withdrawn during WAIT.
    cyc(16'h0100, 1'b0);
    for (int k = 0; k < 5; k++) cyc('0, 1'b0);
    check("t6_held", 32'(grant), 32'h100);
    cyc('0, 1'b1);

    // alu_done coincides with the last watchdog cycle.
    cyc(16'h0002, 1'b0);
    cyc('0, 1'b0);
    for (int k = 0; k < TO - 1; k++) cyc('0, 1'b0);
    cyc('0, 1'b1);
    check("t6_coinc_to", 32'(timeout), 32'd0);
    check("t6_coinc_rel", 32'(grant_valid), 32'd0);
    cyc('0, 1'b0);

    // Randomized traffic.
    slow = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) slow = ($urandom_range(0, 2) == 0);
      r = N'($urandom);
      if ($urandom_range(0, 1) == 0) r = r & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 4) == 0) r = '0;
      d = ($urandom_range(0, slow ? 80 : 4) == 0);
      cyc(r, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
